// File: rtl/seq_control_if.sv
// Sequencer-to-datapath bundle: instruction fields and status in, control strobes out.
// The sequencer connects through the slave modport.
interface seq_control_if #(
  parameter int CYW = 3
);
  logic [4:0]     opcode;
  logic [2:0]     func;
  logic           sign_f;
  logic           zero_f;
  logic           stall;
  logic           step_mode;
  logic           step_req;
  logic           pc_en;
  logic           memwr_en;
  logic           memrd_en;
  logic           regwr_en;
  logic           ins_dat;
  logic           mem_alu;
  logic           alusrc;
  logic           jump;
  logic           branch;
  logic [2:0]     aluopr;
  logic [2:0]     alufunc;
  logic [CYW-1:0] cycle;
  logic           last_cycle;
  logic           halted;
  logic           step_ack;

  modport master (
    output opcode, func, sign_f, zero_f, stall, step_mode, step_req,
    input  pc_en, memwr_en, memrd_en, regwr_en, ins_dat, mem_alu, alusrc,
           jump, branch, aluopr, alufunc, cycle, last_cycle, halted, step_ack
  );

  modport slave (
    input  opcode, func, sign_f, zero_f, stall, step_mode, step_req,
    output pc_en, memwr_en, memrd_en, regwr_en, ins_dat, mem_alu, alusrc,
           jump, branch, aluopr, alufunc, cycle, last_cycle, halted, step_ack
  );
endinterface

// File: rtl/seq_control.sv
// Multi-cycle instruction sequencer for the 5-bit-opcode core: decode, cycle counting,
// datapath strobes, stall, debug single-step and sticky halt.
module seq_control #(
  parameter int MEM_CYC = 2,
  parameter int MUL_CYC = 2,
  parameter int MOD_CYC = 4,
  parameter int CYW     = 3
) (
  input logic        clock,
  input logic        reset_n,
  seq_control_if.slave bus
);
  // Opcode map of the core
  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_LDA = 5'b00001;
  localparam logic [4:0] OP_LDD = 5'b00010;
  localparam logic [4:0] OP_LDM = 5'b00011;
  localparam logic [4:0] OP_STA = 5'b00100;
  localparam logic [4:0] OP_STR = 5'b00101;
  localparam logic [4:0] OP_LDR = 5'b00110;
  localparam logic [4:0] OP_LDI = 5'b00111;
  localparam logic [4:0] OP_ADD = 5'b01000;
  localparam logic [4:0] OP_SUB = 5'b01001;
  localparam logic [4:0] OP_AND = 5'b01010;
  localparam logic [4:0] OP_ORR = 5'b01011;
  localparam logic [4:0] OP_MUL = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_ADI = 5'b01110;
  localparam logic [4:0] OP_SUI = 5'b01111;
  localparam logic [4:0] OP_BZR = 5'b10100;
  localparam logic [4:0] OP_BEQ = 5'b10101;
  localparam logic [4:0] OP_BPV = 5'b10110;
  localparam logic [4:0] OP_BNG = 5'b10111;
  localparam logic [4:0] OP_HLT = 5'b11111;

  localparam logic [CYW-1:0] MEM_M1 = CYW'(MEM_CYC - 1);
  localparam logic [CYW-1:0] MUL_M1 = CYW'(MUL_CYC - 1);
  localparam logic [CYW-1:0] MOD_M1 = CYW'(MOD_CYC - 1);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

  state_t         state_q, state_d;
  logic [CYW-1:0] cycle_q, cycle_d;
  logic [4:0]     op_q, op_d;
  logic           func0_q, func0_d;
  logic           sign_q, sign_d, zero_q, zero_d;
  logic           step_ack_q, step_ack_d;

  // Cycle 0 decodes the live instruction register; later cycles use the latched copy.
  logic [4:0]     op;
  logic           func0;
  logic [CYW-1:0] len_m1;
  logic           is_alu, do_wr, is_mem, is_ins, is_st, src_reg, is_jmp, is_hlt, br_cond;
  logic [2:0]     opr, fn;
  logic           last, run, adv;

  assign op    = (cycle_q == '0) ? bus.opcode : op_q;
  assign func0 = (cycle_q == '0) ? bus.func[0] : func0_q;

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    len_m1  = '0;
    is_alu  = 1'b0;
    do_wr   = 1'b0;
    is_mem  = 1'b0;
    is_ins  = 1'b0;
    is_st   = 1'b0;
    src_reg = 1'b0;
    is_jmp  = 1'b0;
    is_hlt  = 1'b0;
    br_cond = 1'b0;
    opr     = 3'b001;
    fn      = 3'b000;
    casez (op)
      OP_LDA: begin is_mem = 1'b1; is_ins = 1'b1; do_wr = 1'b1; len_m1 = MEM_M1; end
      OP_LDD: begin is_mem = 1'b1; do_wr = 1'b1; len_m1 = MEM_M1; opr = 3'b000; end
      OP_LDM: begin is_mem = 1'b1; is_ins = 1'b1; do_wr = 1'b1; len_m1 = MEM_M1; opr = 3'b000; end
      OP_STA: begin is_mem = 1'b1; is_ins = 1'b1; is_st = 1'b1; len_m1 = MEM_M1; end
      OP_STR: begin is_mem = 1'b1; is_ins = 1'b1; is_st = 1'b1; len_m1 = MEM_M1; opr = 3'b000; end
      OP_LDR: do_wr = 1'b1;
      OP_LDI: begin do_wr = 1'b1; opr = 3'b011; end
      OP_ADD, OP_AND, OP_ORR, OP_XOR: begin
        is_alu = 1'b1; do_wr = 1'b1; src_reg = 1'b1; opr = op[2:0];
      end
      OP_SUB: begin
        // func[0]=1 is a compare: flags only, no writeback
        is_alu = 1'b1; do_wr = ~func0; src_reg = 1'b1; opr = op[2:0];
      end
      OP_MUL: begin
        is_alu = 1'b1; do_wr = 1'b1; src_reg = 1'b1; opr = op[2:0];
        len_m1 = func0 ? MOD_M1 : MUL_M1;
        fn     = func0 ? 3'b001 : 3'b000;
      end
      OP_ADI: begin do_wr = 1'b1; opr = 3'b000; end
      OP_SUI: begin do_wr = 1'b1; opr = 3'b010; end
      OP_BZR, OP_BEQ: begin br_cond = zero_q;  opr = op[2:0]; end
      OP_BPV:         begin br_cond = ~sign_q; opr = op[2:0]; end
      OP_BNG:         begin br_cond = sign_q;  opr = op[2:0]; end
      5'b110??:       begin is_jmp = 1'b1;     opr = op[2:0]; end
      OP_HLT:         is_hlt = 1'b1;
      default: ;
    endcase
  end

  // Gating on reset_n keeps write strobes quiet for the whole time reset is held.
  assign last = (cycle_q == len_m1);
  assign run  = reset_n && (state_q == ST_RUN);
  assign adv  = run && !bus.stall;

  assign bus.pc_en      = adv && last && !is_hlt;
  assign bus.regwr_en   = adv && last && do_wr;
  assign bus.memwr_en   = adv && last && is_st;
  assign bus.memrd_en   = ~bus.memwr_en;
  assign bus.ins_dat    = run && is_ins && (cycle_q != '0);
  assign bus.mem_alu    = run && is_mem && (cycle_q != '0);
  assign bus.alusrc     = run && src_reg;
  assign bus.aluopr     = run ? opr : 3'b000;
  assign bus.alufunc    = run ? fn : 3'b000;
  assign bus.jump       = adv && is_jmp;
  assign bus.branch     = adv && br_cond;
  assign bus.cycle      = cycle_q;
  assign bus.last_cycle = run && last;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.step_ack   = step_ack_q;

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    op_d       = op_q;
    func0_d    = func0_q;
    sign_d     = sign_q;
    zero_d     = zero_q;
    step_ack_d = 1'b0;
    if (adv && cycle_q == '0) begin
      op_d    = bus.opcode;
      func0_d = bus.func[0];
    end
    if (adv && last && is_alu) begin
      sign_d = bus.sign_f;
      zero_d = bus.zero_f;
    end
    unique case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          if (last) begin
            cycle_d = '0;
            if (is_hlt) begin
              state_d = ST_HALT;
            end else if (bus.step_mode) begin
              state_d    = ST_WAIT;
              step_ack_d = 1'b1;
            end
          end else begin
            cycle_d = cycle_q + 1'b1;
          end
        end
      end
      ST_WAIT: if (bus.step_req || !bus.step_mode) state_d = ST_RUN;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      cycle_q    <= '0;
      op_q       <= OP_NOP;
      func0_q    <= 1'b0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      step_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      op_q       <= op_d;
      func0_q    <= func0_d;
      sign_q     <= sign_d;
      zero_q     <= zero_d;
      step_ack_q <= step_ack_d;
    end
  end
endmodule

// File: tb/tb_seq_control.sv
// Directed self-checking bench for seq_control with default latencies
// (MEM_CYC=2, MUL_CYC=2, MOD_CYC=4).
module tb_seq_control;
  localparam logic [4:0] NOP = 5'b00000, LDA = 5'b00001, STA = 5'b00100, LDI = 5'b00111;
  localparam logic [4:0] ADD = 5'b01000, SUB = 5'b01001, MUL = 5'b01100;
  localparam logic [4:0] BZR = 5'b10100, BPV = 5'b10110, BNG = 5'b10111;
  localparam logic [4:0] JMP = 5'b11000, HLT = 5'b11111;

  logic clock = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_control_if #(.CYW(3)) bus ();

  seq_control #(.MEM_CYC(2), .MUL_CYC(2), .MOD_CYC(4), .CYW(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.opcode    = ADD;
    bus.func      = 3'b000;
    bus.sign_f    = 1'b0;
    bus.zero_f    = 1'b0;
    bus.stall     = 1'b0;
    bus.step_mode = 1'b0;
    bus.step_req  = 1'b0;
    #1;
    check("rst_pc_en", bus.pc_en, 0);
    check("rst_regwr", bus.regwr_en, 0);
    check("rst_memrd", bus.memrd_en, 1);
    check("rst_halted", bus.halted, 0);
    check("rst_step_ack", bus.step_ack, 0);
    check("rst_cycle", bus.cycle, 0);
    #12 reset_n = 1'b1;

    // ADD: single cycle, register operand
    #1;
    check("add_pc_en", bus.pc_en, 1);
    check("add_regwr", bus.regwr_en, 1);
    check("add_alusrc", bus.alusrc, 1);
    check("add_aluopr", bus.aluopr, 3'b000);
    check("add_last", bus.last_cycle, 1);
    next();

    // Modulo (MUL with func[0]=1): four cycles, opcode input changes after capture
    bus.opcode = MUL;
    bus.func   = 3'b001;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        bus.opcode = NOP;
        bus.func   = 3'b000;
      end
      #1;
      check($sformatf("mod_cycle%0d", i), bus.cycle, i);
      check($sformatf("mod_alufunc%0d", i), bus.alufunc, 3'b001);
      check($sformatf("mod_regwr%0d", i), bus.regwr_en, (i == 3));
      check($sformatf("mod_pc_en%0d", i), bus.pc_en, (i == 3));
      next();
    end
    check("mod_wrap", bus.cycle, 0);

    // STA stalled in its second cycle
    bus.opcode = STA;
    #1;
    check("sta_c0_memwr", bus.memwr_en, 0);
    check("sta_c0_insdat", bus.ins_dat, 0);
    next();
    bus.stall  = 1'b1;
    bus.opcode = NOP;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sta_stall_memwr", bus.memwr_en, 0);
      check("sta_stall_pc_en", bus.pc_en, 0);
      check("sta_stall_cycle", bus.cycle, 1);
      check("sta_stall_insdat", bus.ins_dat, 1);
      next();
    end
    bus.stall = 1'b0;
    #1;
    check("sta_memwr", bus.memwr_en, 1);
    check("sta_memrd", bus.memrd_en, 0);
    check("sta_insdat", bus.ins_dat, 1);
    check("sta_pc_en", bus.pc_en, 1);
    check("sta_regwr", bus.regwr_en, 0);
    next();

    // Compare sets zero flag; LDA must not disturb it; branches use latched flags
    bus.opcode = SUB;
    bus.func   = 3'b001;
    bus.zero_f = 1'b1;
    #1;
    check("cmp_regwr", bus.regwr_en, 0);
    check("cmp_aluopr", bus.aluopr, 3'b001);
    next();
    bus.opcode = LDA;
    bus.func   = 3'b000;
    bus.zero_f = 1'b0;
    #1;
    check("lda_c0_memalu", bus.mem_alu, 0);
    next();
    #1;
    check("lda_c1_memalu", bus.mem_alu, 1);
    check("lda_c1_regwr", bus.regwr_en, 1);
    next();
    bus.opcode = BZR;
    #1;
    check("bzr_branch", bus.branch, 1);
    check("bzr_aluopr", bus.aluopr, 3'b100);
    next();
    bus.opcode = BNG;
    #1;
    check("bng_branch", bus.branch, 0);
    next();
    bus.opcode = BPV;
    #1;
    check("bpv_branch", bus.branch, 1);
    next();
    bus.opcode = JMP;
    #1;
    check("jmp_jump", bus.jump, 1);
    check("jmp_pc_en", bus.pc_en, 1);
    next();

    // Single-step: ADD retires into WAIT, then one LDI per step_req
    bus.step_mode = 1'b1;
    bus.opcode    = ADD;
    #1;
    check("step_add_regwr", bus.regwr_en, 1);
    next();
    bus.opcode = LDI;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("wait_step_ack", bus.step_ack, (i == 0));
      check("wait_pc_en", bus.pc_en, 0);
      check("wait_regwr", bus.regwr_en, 0);
      next();
    end
    bus.step_req = 1'b1;
    next();
    bus.step_req = 1'b0;
    #1;
    check("step_ldi_regwr", bus.regwr_en, 1);
    check("step_ldi_aluopr", bus.aluopr, 3'b011);
    next();
    #1;
    check("step2_ack", bus.step_ack, 1);
    check("step2_pc_en", bus.pc_en, 0);
    next();
    #1;
    check("step2_ack_done", bus.step_ack, 0);
    check("step2_idle_regwr", bus.regwr_en, 0);
    bus.step_mode = 1'b0;
    next();
    #1;
    check("resume_regwr", bus.regwr_en, 1);
    next();

    // HLT is sticky against step_req/stall; reset clears it asynchronously
    bus.opcode = HLT;
    #1;
    check("hlt_pc_en", bus.pc_en, 0);
    check("hlt_halted_c0", bus.halted, 0);
    next();
    bus.opcode = ADD;
    for (int i = 0; i < 6; i++) begin
      bus.step_req  = i[0];
      bus.stall     = i[1];
      bus.step_mode = i[2];
      #1;
      check("halt_halted", bus.halted, 1);
      check("halt_pc_en", bus.pc_en, 0);
      check("halt_regwr", bus.regwr_en, 0);
      next();
    end
    bus.step_req  = 1'b0;
    bus.stall     = 1'b0;
    bus.step_mode = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst2_halted", bus.halted, 0);
    check("rst2_pc_en", bus.pc_en, 0);
    reset_n = 1'b1;
    #1;
    check("post_rst_pc_en", bus.pc_en, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_control.md
Name: seq_control

Overview:
Parametrised multi-cycle instruction sequencer for the 5-bit-opcode core. It decodes the opcode and runs a per-instruction cycle counter with configurable latencies for memory, multiply and modulo instructions. It produces the datapath control strobes and supports pipeline stall, a debug single-step handshake and a sticky halt. It sits between the instruction register and the datapath (PC, register file, ALU, memory port).

Parameters:
MEM_CYC, 2, cycles for LDA/LDD/LDM/STA/STR (1..2^CYW)
MUL_CYC, 2, cycles for MUL with func[0]=0 (1..2^CYW)
MOD_CYC, 4, cycles for MUL with func[0]=1, i.e. MOD (1..2^CYW)
CYW, 3, width of the cycle counter

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
opcode  in  5  current instruction opcode
func  in  3  function field; only func[0] is used
sign_f  in  1  ALU sign result, current cycle
zero_f  in  1  ALU zero result, current cycle
stall  in  1  freeze sequencer (memory not ready)
step_mode  in  1  1 = single-step debug mode
step_req  in  1  one-cycle pulse: execute one instruction
pc_en  out  1  PC advance
memwr_en  out  1  memory write
memrd_en  out  1  always ~memwr_en
regwr_en  out  1  register file write
ins_dat  out  1  0 = instruction address, 1 = data address
mem_alu  out  1  1 = writeback from memory
alusrc  out  1  1 = register operand, 0 = immediate
jump  out  1  take jump
branch  out  1  take branch
aluopr  out  3  ALU operation
alufunc  out  3  ALU sub-function
cycle  out  CYW  index of the current cycle within the instruction
last_cycle  out  1  current cycle retires the instruction
halted  out  1  HLT executed
step_ack  out  1  one-cycle pulse when a stepped instruction retires

Behaviour:
- Reset values:
  - State RUN, cycle=0, latched opcode/func = NOP, flags = 0, step_ack = 0, halted = 0.
  - All strobes 0 except memrd_en = 1.
- Opcode capture: opcode/func are latched on each clock edge where cycle=0 and the sequencer advances. For cycle>0, decode uses the latched copy.
- Instruction length L:
  - LDA/LDD/LDM/STA/STR: MEM_CYC.
  - MUL with func[0]=0: MUL_CYC.
  - MUL with func[0]=1 (MOD): MOD_CYC.
  - All others: 1. Unknown opcodes decode as NOP.
- Cycle counter: last_cycle = (cycle == L-1). On an advance, cycle goes to 0 when last_cycle=1, otherwise it increments.
- Advance condition: state RUN and stall=0.
  - While stall=1, the counter and latches hold.
  - While stall=1, pc_en, memwr_en and regwr_en are forced to 0. Other outputs keep their decoded values.
- Strobes, all gated by the advance condition:
  - pc_en = last_cycle.
  - regwr_en on last_cycle for LDA/LDD/LDM/LDR/LDI/ADD/ADI/SUB(func[0]=0)/SUI/MUL/AND/ORR/XOR.
  - SUB with func[0]=1 (compare) never writes.
  - memwr_en on last_cycle for STA/STR only.
- Memory instructions:
  - ins_dat = 1 for cycle>0 of LDA/LDM/STA/STR.
  - mem_alu = 1 on cycle>0 of every memory instruction.
- alusrc: 1 for register-register ALU ops and MUL, 0 otherwise.
- aluopr:
  - opcode[2:0] for ADD/SUB/MUL/AND/ORR/XOR/branches/JMP.
  - 3'b011 for LDI.
  - 3'b010 for SUI.
  - 3'b000 for ADI/LDD/LDM/STR.
  - 3'b001 otherwise.
- alufunc: 3'b001 for MOD, else 3'b000.
- Flags:
  - sign/zero are latched only on retirement of ALU-class instructions: ADD..XOR including compare.
  - Flags are not updated by loads, stores, branches or stalls.
- Branch conditions:
  - BZR/BEQ: branch = zero_flag.
  - BPV: branch = ~sign_flag.
  - BNG: branch = sign_flag.
  - branch is asserted only while advancing.
- jump = 1 for opcode 5'b110xx while advancing.
- HLT (5'b11111): enters HALT on its single cycle. pc_en=0 on that cycle.
  - halted=1 from the next cycle; all strobes 0.
  - HALT exits only via reset. stall and step_req are ignored in HALT.
- Single-step:
  - If step_mode=1 at the retirement of any instruction, the state goes to WAIT and step_ack pulses for one cycle.
  - In WAIT, all strobes are 0 and the counter holds at 0.
  - step_req=1 in WAIT returns the state to RUN for exactly one instruction.
  - step_mode falling to 0 while in WAIT returns to RUN on the next edge.
  - step_req outside WAIT is ignored.
- Stall and step_req arriving together in WAIT: the transition to RUN occurs, and the first cycle is then stalled normally.
- Reset mid-instruction aborts immediately. No partial write is issued after reset asserts.

Test Plan:
- Reset, then ADD (5'b01000) with stall=0 -> pc_en=1, regwr_en=1, alusrc=1, aluopr=3'b000, last_cycle=1 in one cycle.
- MOD (opcode 5'b01100, func=3'b001), MOD_CYC=4 -> cycle 0,1,2,3. regwr_en and pc_en only on cycle 3; alufunc=3'b001 throughout. The opcode input changing at cycle 1 has no effect.
- STA with stall=1 held on cycle 1 for 3 clocks -> memwr_en stays 0 and cycle stays 1. After stall=0: memwr_en=1, ins_dat=1, pc_en=1 in the same cycle.
- SUB compare with func[0]=1 giving zero_f=1, then LDA with zero_f=0, then BZR -> branch=1 (the LDA did not update the flag); no regwr_en on the compare.
- step_mode=1 with ADD, LDI, LDI -> step_ack pulses after ADD and strobes are idle for 5 clocks. A step_req pulse runs LDI only and a second step_ack follows.
- HLT then step_req and stall toggling -> halted=1 and pc_en=0 forever. Asserting reset_n=0 clears halted=0 asynchronously.
